uart_tx_arbiter: RTL and testbench

Shares one uart_transmitter between NUM_REQ byte-stream requesters (e.g. CPU debug printf, trace unit, bootloader echo).
- Grants are packet-granular and round-robin.
- A granted requester owns the transmitter until it hands over a byte flagged last.
- Drives the transmitter's write_data/write_req/ready handshake, including its one-cycle ready latency after a write.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 141 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter and its round-robin picker.
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        OWNED,
        ISSUE,
        SETTLE,
        WAIT_TX
    } arb_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first active request at or after the pointer,
// wrapping modulo NUM_REQ. Pointer must be below NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               valid_o
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [NUM_REQ-1:0]   pick;
    logic [2*NUM_REQ-1:0] gnt_dbl;

    // Rotate so the pointer position sits at bit 0, pick lowest, rotate back.
    always_comb begin
        req_dbl = {req_i, req_i};
        req_rot = NUM_REQ'(req_dbl >> ptr_i);
        pick    = '0;
        valid_o = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_rot[k] && !valid_o) begin
                pick[k] = 1'b1;
                valid_o = 1'b1;
            end
        end
        gnt_dbl = {{NUM_REQ{1'b0}}, pick} << ptr_i;
        gnt_o   = gnt_dbl[NUM_REQ-1:0] | gnt_dbl[2*NUM_REQ-1:NUM_REQ];
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmitter between
// NUM_REQ byte-stream requesters, with an idle-timeout on a stalled owner.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int IDLE_TIMEOUT = 1023
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*UART_BYTE_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             grant,
    output logic [UART_BYTE_W-1:0]         tx_write_data,
    output logic                           tx_write_req,
    input  logic                           tx_ready,
    output logic                           timeout_pulse
);

    localparam int IDX_W = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;
    localparam int CNT_W = (IDLE_TIMEOUT > 0) ? clog2(IDLE_TIMEOUT + 1) : 1;
    localparam bit TO_EN = (IDLE_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_EN ? IDLE_TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    arb_state_e             state_q;
    logic [NUM_REQ-1:0]     grant_q;
    logic [IDX_W-1:0]       ptr_q;
    logic [CNT_W-1:0]       idle_cnt_q;
    logic [UART_BYTE_W-1:0] tx_data_q;
    logic                   tx_req_q;
    logic                   last_q;
    logic                   timeout_q;

    logic [NUM_REQ-1:0]     win_gnt;
    logic                   win_valid;
    logic [IDX_W-1:0]       owner_idx;
    logic [IDX_W-1:0]       next_ptr;
    logic [UART_BYTE_W-1:0] own_data;
    logic                   own_last;
    logic                   accept;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (IDX_W)
    ) u_rr (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .gnt_o   (win_gnt),
        .valid_o (win_valid)
    );

    always_comb begin
        owner_idx = '0;
        own_data  = '0;
        own_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                owner_idx = IDX_W'(i);
                own_data  = req_data[i*UART_BYTE_W +: UART_BYTE_W];
                own_last  = req_last[i];
            end
        end
    end

    assign next_ptr  = (owner_idx == IDX_W'(NUM_REQ - 1)) ? '0 : owner_idx + 1'b1;
    assign req_ready = (state_q == OWNED) ? (grant_q & req_valid & {NUM_REQ{tx_ready}}) : '0;
    assign accept    = |req_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ptr_q      <= '0;
            idle_cnt_q <= '0;
            tx_data_q  <= '0;
            tx_req_q   <= 1'b0;
            last_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            tx_req_q  <= 1'b0;
            timeout_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (win_valid) begin
                        grant_q    <= win_gnt;
                        idle_cnt_q <= '0;
                        state_q    <= OWNED;
                    end
                end
                OWNED: begin
                    if (accept) begin
                        tx_data_q  <= own_data;
                        last_q     <= own_last;
                        tx_req_q   <= 1'b1;
                        idle_cnt_q <= '0;
                        state_q    <= ISSUE;
                    end else if (TO_EN && (idle_cnt_q == TO_LAST)) begin
                        grant_q    <= '0;
                        timeout_q  <= 1'b1;
                        ptr_q      <= next_ptr;
                        idle_cnt_q <= '0;
                        state_q    <= IDLE;
                    end else if (idle_cnt_q != CNT_MAX) begin
                        idle_cnt_q <= idle_cnt_q + 1'b1;
                    end
                end
                ISSUE: begin
                    state_q <= SETTLE;
                end
                // The transmitter drops ready one cycle late, so this cycle's ready is stale.
                SETTLE: begin
                    state_q <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (tx_ready) begin
                        idle_cnt_q <= '0;
                        if (last_q) begin
                            grant_q <= '0;
                            ptr_q   <= next_ptr;
                            state_q <= IDLE;
                        end else begin
                            state_q <= OWNED;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant         = grant_q;
    assign tx_write_data = tx_data_q;
    assign tx_write_req  = tx_req_q;
    assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues, a transmitter model with
// one-cycle ready latency, and a scoreboard of expected {owner, byte} writes.
module tb_uart_tx_arbiter;

    localparam int NREQ = 2;
    localparam int TMO  = 8;
    localparam int BUSY = 20;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic [1:0]  grant;
    logic [7:0]  tx_write_data;
    logic        tx_write_req;
    logic        tx_ready;
    logic        timeout_pulse;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ      (NREQ),
        .IDLE_TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .grant         (grant),
        .tx_write_data (tx_write_data),
        .tx_write_req  (tx_write_req),
        .tx_ready      (tx_ready),
        .timeout_pulse (timeout_pulse)
    );

    int         n_chk;
    int         n_fail;
    logic [8:0] rq0[$];
    logic [8:0] rq1[$];
    logic [9:0] exp_q[$];
    logic [1:0] gseq[$];
    logic [1:0] gprev;
    logic [1:0] rdy_s;
    logic [9:0] e;
    int         cyc, wr_cnt, last_wr, last_gap, rdy_rise, to_cyc, to_cnt, busy;
    logic       lat1, lat2, fault, nr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic drive_reqs();
        req_valid[0]   = (rq0.size() != 0);
        req_data[7:0]  = (rq0.size() != 0) ? rq0[0][7:0] : 8'h00;
        req_last[0]    = (rq0.size() != 0) ? rq0[0][8] : 1'b0;
        req_valid[1]   = (rq1.size() != 0);
        req_data[15:8] = (rq1.size() != 0) ? rq1[0][7:0] : 8'h00;
        req_last[1]    = (rq1.size() != 0) ? rq1[0][8] : 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int target);
        int k;
        k = 0;
        while (k < 400 && !(wr_cnt >= target && grant == 2'b00 && tx_ready && exp_q.size() == 0)) begin
            @(negedge clk);
            k++;
        end
        check(tag, (k < 400), 1);
        repeat (2) @(negedge clk);
    endtask

    // Environment: requester pops, transmitter model, write scoreboard, event log.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (!reset_n) begin
            busy     = 0;
            lat1     = 1'b0;
            lat2     = 1'b0;
            tx_ready = 1'b1;
            last_wr  = -1;
            gprev    = grant;
        end else begin
            if (rdy_s[0] && rq0.size() != 0) void'(rq0.pop_front());
            if (rdy_s[1] && rq1.size() != 0) void'(rq1.pop_front());
            if (tx_write_req) begin
                check("wr_while_ready", tx_ready, 1);
                if (last_wr >= 0) begin
                    last_gap = cyc - last_wr;
                    check("wr_gap_ge4", (last_gap >= 4), 1);
                end
                last_wr = cyc;
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    check("wr_unexpected", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_data", tx_write_data, e[7:0]);
                    check("wr_owner", grant, e[9:8]);
                end
            end
            if (lat2 && !fault) busy = BUSY;
            else if (busy > 0) busy--;
            lat2 = lat1;
            lat1 = tx_write_req;
            nr = fault || (busy == 0);
            if (nr && !tx_ready) rdy_rise = cyc;
            tx_ready = nr;
            if (timeout_pulse) begin
                to_cnt++;
                to_cyc = cyc;
            end
            if (grant != gprev) gseq.push_back(grant);
            gprev = grant;
        end
        rdy_s = 2'b00;
        drive_reqs();
    end

    always @(negedge clk) begin
        rdy_s = req_ready;
        if (req_ready != 2'b00) check("ready_in_grant", req_ready & ~grant, 2'b00);
    end

    initial begin
        int         base;
        int         k;
        logic [7:0] gs;
        n_chk = 0; n_fail = 0; fault = 1'b0; reset_n = 1'b0; tx_ready = 1'b1;
        busy = 0; lat1 = 1'b0; lat2 = 1'b0; cyc = 0; wr_cnt = 0; last_wr = -1; last_gap = 0;
        to_cnt = 0; to_cyc = 0; rdy_rise = 0; rdy_s = 2'b00; gprev = 2'b00;
        drive_reqs();
        repeat (3) @(negedge clk);
        check("rst_grant", grant, 2'b00);
        check("rst_wr_req", tx_write_req, 0);
        check("rst_wr_data", tx_write_data, 8'h00);
        check("rst_timeout", timeout_pulse, 0);
        check("rst_ready", req_ready, 2'b00);
        reset_n = 1'b1;

        // Single requester, two-byte packet, slow transmitter.
        base = wr_cnt;
        rq0.push_back({1'b0, 8'h41}); rq0.push_back({1'b1, 8'h42});
        exp_q.push_back({2'b01, 8'h41}); exp_q.push_back({2'b01, 8'h42});
        drive_reqs();
        k = 0;
        while (k < 200 && wr_cnt < base + 2) begin @(negedge clk); k++; end
        check("t1_writes", (wr_cnt >= base + 2), 1);
        k = 0;
        while (k < 20 && tx_ready) begin @(negedge clk); k++; end
        k = 0;
        while (k < 100 && !tx_ready) begin @(negedge clk); k++; end
        check("t1_ready_back", tx_ready, 1);
        check("t1_grant_held", grant, 2'b01);
        @(negedge clk);
        check("t1_grant_released", grant, 2'b00);
        wait_idle("t1_done", base + 2);

        // Both requesters valid out of reset, one-byte packets.
        reset_n = 1'b0;
        rq0.push_back({1'b1, 8'hA0}); rq1.push_back({1'b1, 8'hB1});
        exp_q.push_back({2'b01, 8'hA0}); exp_q.push_back({2'b10, 8'hB1});
        drive_reqs();
        @(negedge clk);
        gseq.delete();
        base = wr_cnt;
        reset_n = 1'b1;
        wait_idle("t2_done", base + 2);
        check("t2_grant_steps", gseq.size(), 4);
        gs = 8'h00;
        foreach (gseq[i]) gs = {gs[5:0], gseq[i]};
        check("t2_grant_seq", gs, 8'h48);

        // Three-byte packet from 0 while 1 waits.
        base = wr_cnt;
        rq0.push_back({1'b0, 8'h10}); rq0.push_back({1'b0, 8'h11}); rq0.push_back({1'b1, 8'h12});
        rq1.push_back({1'b1, 8'hC0});
        exp_q.push_back({2'b01, 8'h10}); exp_q.push_back({2'b01, 8'h11});
        exp_q.push_back({2'b01, 8'h12}); exp_q.push_back({2'b10, 8'hC0});
        drive_reqs();
        wait_idle("t3_done", base + 4);

        // Requester 1 stalls mid-packet; grant revoked by timeout.
        rq1.push_back({1'b0, 8'hD1});
        exp_q.push_back({2'b10, 8'hD1});
        drive_reqs();
        k = 0;
        while (k < 300 && to_cnt < 1) begin @(negedge clk); k++; end
        check("t4_timeout_seen", to_cnt, 1);
        check("t4_timeout_delay", to_cyc - rdy_rise, 9);
        check("t4_grant_revoked", grant, 2'b00);
        repeat (3) @(negedge clk);
        check("t4_pulse_single", to_cnt, 1);
        base = wr_cnt;
        rq0.push_back({1'b1, 8'hE0}); rq1.push_back({1'b1, 8'hF1});
        exp_q.push_back({2'b01, 8'hE0}); exp_q.push_back({2'b10, 8'hF1});
        drive_reqs();
        wait_idle("t4_done", base + 2);

        // Asynchronous reset while waiting on the transmitter.
        base = wr_cnt;
        rq0.push_back({1'b1, 8'h30});
        exp_q.push_back({2'b01, 8'h30});
        drive_reqs();
        wait_idle("t5_pre", base + 1);
        base = wr_cnt;
        rq1.push_back({1'b0, 8'h33}); rq1.push_back({1'b1, 8'h34});
        exp_q.push_back({2'b10, 8'h33});
        drive_reqs();
        k = 0;
        while (k < 100 && wr_cnt <= base) begin @(negedge clk); k++; end
        repeat (5) @(negedge clk);
        check("t5_owner_before", grant, 2'b10);
        check("t5_data_before", tx_write_data, 8'h33);
        reset_n = 1'b0;
        #1;
        check("t5_async_grant", grant, 2'b00);
        check("t5_async_data", tx_write_data, 8'h00);
        check("t5_async_wr_req", tx_write_req, 0);
        check("t5_async_timeout", timeout_pulse, 0);
        rq1.delete();
        drive_reqs();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        base = wr_cnt;
        rq0.push_back({1'b1, 8'h61}); rq1.push_back({1'b1, 8'h71});
        exp_q.push_back({2'b01, 8'h61}); exp_q.push_back({2'b10, 8'h71});
        drive_reqs();
        wait_idle("t5_done", base + 2);

        // Transmitter ready stuck high: spacing must come from the arbiter alone.
        fault = 1'b1;
        base = wr_cnt;
        rq0.push_back({1'b0, 8'h81}); rq0.push_back({1'b0, 8'h82}); rq0.push_back({1'b1, 8'h83});
        exp_q.push_back({2'b01, 8'h81}); exp_q.push_back({2'b01, 8'h82}); exp_q.push_back({2'b01, 8'h83});
        drive_reqs();
        wait_idle("t6_done", base + 3);
        check("t6_gap", last_gap, 4);
        fault = 1'b0;

        check("queue_drained", exp_q.size(), 0);
        check("timeouts_total", to_cnt, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
